bf16_dot_acc: RTL and testbench

Streaming bfloat16 dot-product accumulator that sits on the result side of the existing combinational bf16 MAC datapath. It accepts a vector of (a, b) operand pairs over a valid/ready stream, feeds its own running sum back as the MAC addend each beat, and presents the final sum on a valid/ready output port. It is the sequential consumer and sequencer for the MAC, the block that turns a one-shot a*b+c into a multi-term accumulation.

---
 rtl/bf16_dot_acc_pkg.sv | 23 ++
 rtl/bf16_dot_acc_if.sv | 30 +++
 rtl/bf16_dot_acc_mac.sv | 98 +++++++++
 rtl/bf16_dot_acc.sv | 87 ++++++++
 tb/tb_bf16_dot_acc.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bf16_dot_acc_pkg.sv
// Shared bf16 definitions for the dot-product accumulator: field widths,
// canonical NaN, sequencer state encoding and the NaN classifier.
package bf16_dot_acc_pkg;

   localparam int SIGN_W = 1;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 7;
   localparam int BF16_W = SIGN_W + EXP_W + MAN_W;

   localparam logic [BF16_W-1:0] CANON_NAN = 16'h7FC0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // NaN: exponent all ones with a nonzero mantissa (infinity is not NaN).
   function automatic logic is_nan(input logic [BF16_W-1:0] x);
      return (&x[MAN_W +: EXP_W]) && (|x[MAN_W-1:0]);
   endfunction

endpackage

// File: rtl/bf16_dot_acc_if.sv
// Operand stream in, result stream out, bundled for the accumulator.
interface bf16_dot_acc_if #(
   parameter int N     = 16,
   parameter int CNT_W = 8
);
   // Both streams: a transfer happens on a rising edge where valid && ready;
   // the producer keeps valid and payload stable until that edge.
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_a;
   logic [N-1:0]     in_b;
   logic [N-1:0]     in_bias;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_result;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;
   logic             out_nan;

   modport master (
      output in_valid, in_a, in_b, in_bias, in_last, out_ready,
      input  in_ready, out_valid, out_result, out_count, out_ovf, out_nan
   );

   modport slave (
      input  in_valid, in_a, in_b, in_bias, in_last, out_ready,
      output in_ready, out_valid, out_result, out_count, out_ovf, out_nan
   );
endinterface

// File: rtl/bf16_dot_acc_mac.sv
// Combinational bf16 fused a*b+c: exact product, one round-to-nearest-even,
// subnormals flushed to zero, any invalid case yields the canonical NaN.
module MAC_unpipelined_top
   import bf16_dot_acc_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   output logic [N-1:0] result
);

   logic               sp, big_s, sml_s, res_s, stk, inc;
   logic               a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, p_inf, any_nan;
   logic [15:0]        pm, p_sig, c_sig;
   logic signed [10:0] pexp, cexp, bexp, diff, rexp;
   logic [32:0]        big, sml, shifted, sum, norm;
   logic [5:0]         lead;
   logic [6:0]         man;
   logic [14:0]        mag;
   logic [15:0]        res;

   always_comb begin
      a_zero  = (a[14:7] == 8'd0);
      b_zero  = (b[14:7] == 8'd0);
      c_zero  = (c[14:7] == 8'd0);
      a_inf   = (&a[14:7]) && (a[6:0] == 7'd0);
      b_inf   = (&b[14:7]) && (b[6:0] == 7'd0);
      c_inf   = (&c[14:7]) && (c[6:0] == 7'd0);
      sp      = a[15] ^ b[15];
      p_inf   = (a_inf || b_inf) && !(a_zero || b_zero);
      any_nan = is_nan(a) || is_nan(b) || is_nan(c) ||
                ((a_inf || b_inf) && (a_zero || b_zero)) ||
                (p_inf && c_inf && (sp != c[15]));
      pm = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};

      // Both addends share the scale 2^(exp-127-14); zeros get a tiny exponent.
      if (a_zero || b_zero) begin
         p_sig = '0;
         pexp  = -11'sd512;
      end else begin
         p_sig = pm;
         pexp  = $signed({3'b0, a[14:7]}) + $signed({3'b0, b[14:7]}) - 11'sd127;
      end
      if (c_zero) begin
         c_sig = '0;
         cexp  = -11'sd512;
      end else begin
         c_sig = {1'b0, 1'b1, c[6:0], 7'd0};
         cexp  = $signed({3'b0, c[14:7]});
      end

      if (pexp >= cexp) begin
         big = {1'b0, p_sig, 16'd0}; big_s = sp;    bexp = pexp;
         sml = {1'b0, c_sig, 16'd0}; sml_s = c[15]; diff = pexp - cexp;
      end else begin
         big = {1'b0, c_sig, 16'd0}; big_s = c[15]; bexp = cexp;
         sml = {1'b0, p_sig, 16'd0}; sml_s = sp;    diff = cexp - pexp;
      end

      // Bits shifted out are jammed into the LSB so rounding still sees them.
      if (diff >= 11'sd33) begin
         shifted = '0;
         stk     = |sml;
      end else begin
         shifted = sml >> diff[5:0];
         stk     = ((shifted << diff[5:0]) != sml);
      end
      shifted[0] = shifted[0] | stk;

      if (big_s == sml_s) begin
         sum = big + shifted;  res_s = big_s;
      end else if (big >= shifted) begin
         sum = big - shifted;  res_s = big_s;
      end else begin
         sum = shifted - big;  res_s = sml_s;
      end

      lead = '0;
      for (int i = 0; i < 33; i++) if (sum[i]) lead = 6'(i);
      norm = sum << (6'd32 - lead);
      man  = norm[31:25];
      inc  = norm[24] && ((|norm[23:0]) || man[0]);
      rexp = bexp + $signed({5'd0, lead}) - 11'sd30;
      mag  = {rexp[7:0], man} + {14'd0, inc};

      if (any_nan)                 res = CANON_NAN;
      else if (p_inf)              res = {sp, 8'hFF, 7'd0};
      else if (c_inf)              res = {c[15], 8'hFF, 7'd0};
      else if (!norm[32])          res = 16'h0000;
      else if (rexp <= 11'sd0)     res = {res_s, 15'd0};
      else if (rexp >= 11'sd255)   res = {res_s, 8'hFF, 7'd0};
      else                         res = {res_s, mag};
      result = res;
   end

endmodule

// File: rtl/bf16_dot_acc.sv
// Streaming bf16 dot-product accumulator: sequences the shared MAC over a
// vector, feeding the running sum back as the addend each beat.
module bf16_dot_acc
   import bf16_dot_acc_pkg::*;
#(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   bf16_dot_acc_if.slave      bus,
   output state_e             dbg_state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q;
   logic [N-1:0]     acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q, nan_q;
   logic             first, accept, nan_next;
   logic [N-1:0]     mac_c, mac_r;

   always_comb begin
      first    = (state_q == ST_IDLE);
      accept   = bus.in_valid && (state_q != ST_HOLD);
      mac_c    = first ? bus.in_bias : acc_q;
      nan_next = is_nan(bus.in_a) || is_nan(bus.in_b) || is_nan(mac_r) ||
                 (first && is_nan(bus.in_bias)) || (!first && nan_q);
   end

   MAC_unpipelined_top #(.N(N)) u_mac (
      .a      (bus.in_a),
      .b      (bus.in_b),
      .c      (mac_c),
      .result (mac_r)
   );

   // Once NaN is seen the accumulator itself holds the canonical NaN, so the
   // output register never needs a separate override.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         nan_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept) begin
                  acc_q   <= nan_next ? CANON_NAN : mac_r;
                  nan_q   <= nan_next;
                  state_q <= bus.in_last ? ST_HOLD : ST_ACCUM;
                  if (first) begin
                     cnt_q <= CNT_W'(1);
                     ovf_q <= 1'b0;
                  end else if (cnt_q == CNT_MAX) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  state_q <= ST_IDLE;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
                  nan_q   <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state_q != ST_HOLD);
   assign bus.out_valid  = (state_q == ST_HOLD);
   assign bus.out_result = acc_q;
   assign bus.out_count  = cnt_q;
   assign bus.out_ovf    = ovf_q;
   assign bus.out_nan    = nan_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_bf16_dot_acc.sv
// Directed bench for bf16_dot_acc: a CNT_W=8 instance and a CNT_W=2 instance
// run the same stimulus so counter saturation is seen alongside normal counts.
module tb_bf16_dot_acc;
   import bf16_dot_acc_pkg::*;

   logic   clk;
   logic   rst;
   state_e dbg_state, dbg_state_s;
   int     n_cmp = 0;
   int     n_err = 0;
   logic [15:0] exp_q[$];

   bf16_dot_acc_if #(.N(16), .CNT_W(8)) u_if ();
   bf16_dot_acc_if #(.N(16), .CNT_W(2)) u_if_s ();

   assign u_if_s.in_valid  = u_if.in_valid;
   assign u_if_s.in_a      = u_if.in_a;
   assign u_if_s.in_b      = u_if.in_b;
   assign u_if_s.in_bias   = u_if.in_bias;
   assign u_if_s.in_last   = u_if.in_last;
   assign u_if_s.out_ready = u_if.out_ready;

   bf16_dot_acc #(.N(16), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .bus(u_if), .dbg_state(dbg_state));

   bf16_dot_acc #(.N(16), .CNT_W(2)) u_dut_s (
      .clk(clk), .rst(rst), .bus(u_if_s), .dbg_state(dbg_state_s));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat is taken.
   task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] bias, input logic last);
      int n = 0;
      u_if.in_valid = 1'b1;
      u_if.in_a     = a;
      u_if.in_b     = b;
      u_if.in_bias  = bias;
      u_if.in_last  = last;
      while (!u_if.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check_eq("beat_timeout", 32'(u_if.in_ready), 32'd1);
      @(negedge clk);
      u_if.in_valid = 1'b0;
   endtask

   // Checks the held result against the scoreboard, then completes the handshake.
   task automatic take_result(input int cnt, input logic ovf, input logic nan,
                              input int cnt_s, input logic ovf_s);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
         e = 16'h0000;
      end else begin
         e = exp_q.pop_front();
      end
      check_eq("out_valid",  32'(u_if.out_valid),    32'd1);
      check_eq("in_ready_h", 32'(u_if.in_ready),     32'd0);
      check_eq("result",     32'(u_if.out_result),   32'(e));
      check_eq("count",      32'(u_if.out_count),    32'(cnt));
      check_eq("ovf",        32'(u_if.out_ovf),      32'(ovf));
      check_eq("nan",        32'(u_if.out_nan),      32'(nan));
      check_eq("result_s",   32'(u_if_s.out_result), 32'(e));
      check_eq("count_s",    32'(u_if_s.out_count),  32'(cnt_s));
      check_eq("ovf_s",      32'(u_if_s.out_ovf),    32'(ovf_s));
      u_if.out_ready = 1'b1;
      @(negedge clk);
      u_if.out_ready = 1'b0;
      check_eq("valid_clr",  32'(u_if.out_valid),    32'd0);
      check_eq("ready_back", 32'(u_if.in_ready),     32'd1);
      check_eq("count_clr",  32'(u_if.out_count),    32'd0);
   endtask

   initial begin
      rst            = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.in_a      = '0;
      u_if.in_b      = '0;
      u_if.in_bias   = '0;
      u_if.in_last   = 1'b0;
      u_if.out_ready = 1'b0;

      #12;
      check_eq("rst_in_ready",  32'(u_if.in_ready),   32'd1);
      check_eq("rst_out_valid", 32'(u_if.out_valid),  32'd0);
      check_eq("rst_result",    32'(u_if.out_result), 32'h0000);
      check_eq("rst_count",     32'(u_if.out_count),  32'd0);
      check_eq("rst_ovf",       32'(u_if.out_ovf),    32'd0);
      check_eq("rst_nan",       32'(u_if.out_nan),    32'd0);
      check_eq("rst_state",     32'(dbg_state),       32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;

      // single beat: 1.125 + 0.25*1.0 = 1.375
      exp_q.push_back(16'h3FB0);
      send_beat(16'h3E80, 16'h3F80, 16'h3F90, 1'b1);
      take_result(1, 1'b0, 1'b0, 1, 1'b0);

      // three beats with idle gaps: 18.125, 19.125, 9.125
      send_beat(16'hC020, 16'hC0E8, 16'h0000, 1'b0);
      check_eq("partial1", 32'(u_if.out_result), 32'h4191);
      @(negedge clk);
      @(negedge clk);
      check_eq("gap_hold",  32'(u_if.out_result), 32'h4191);
      check_eq("gap_state", 32'(dbg_state),       32'(ST_ACCUM));
      check_eq("gap_ready", 32'(u_if.in_ready),   32'd1);
      check_eq("gap_valid", 32'(u_if.out_valid),  32'd0);
      send_beat(16'h3F80, 16'h3F80, 16'h1234, 1'b0);
      check_eq("partial2", 32'(u_if.out_result), 32'h4199);
      exp_q.push_back(16'h4112);
      send_beat(16'h4120, 16'hBF80, 16'h0000, 1'b1);
      take_result(3, 1'b0, 1'b0, 3, 1'b0);

      // backpressure with a beat offered during HOLD (2*2 = 4.0)
      send_beat(16'h3E80, 16'h3F80, 16'h3F90, 1'b1);
      u_if.in_valid = 1'b1;
      u_if.in_a     = 16'h4000;
      u_if.in_b     = 16'h4000;
      u_if.in_bias  = 16'h0000;
      u_if.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid",  32'(u_if.out_valid),  32'd1);
         check_eq("bp_result", 32'(u_if.out_result), 32'h3FB0);
         check_eq("bp_ready",  32'(u_if.in_ready),   32'd0);
         @(negedge clk);
      end
      u_if.out_ready = 1'b1;
      @(negedge clk);
      u_if.out_ready = 1'b0;
      check_eq("bp_done_valid", 32'(u_if.out_valid), 32'd0);
      check_eq("bp_done_ready", 32'(u_if.in_ready),  32'd1);
      @(negedge clk);
      u_if.in_valid = 1'b0;
      exp_q.push_back(16'h4080);
      take_result(1, 1'b0, 1'b0, 1, 1'b0);

      // NaN on beat 1 propagates as canonical NaN
      send_beat(16'h7FC0, 16'h3F80, 16'h0000, 1'b0);
      exp_q.push_back(16'h7FC0);
      send_beat(16'h3F80, 16'h3F80, 16'h0000, 1'b1);
      take_result(2, 1'b0, 1'b1, 2, 1'b0);

      // NaN bias on a later beat is not sampled: 1 + 1 = 2.0
      send_beat(16'h3F80, 16'h3F80, 16'h0000, 1'b0);
      exp_q.push_back(16'h4000);
      send_beat(16'h3F80, 16'h3F80, 16'h7FC1, 1'b1);
      take_result(2, 1'b0, 1'b0, 2, 1'b0);

      // rounding: ties to even, down then up; exact cancellation to +0
      exp_q.push_back(16'h3F80);
      send_beat(16'h3F80, 16'h3B80, 16'h3F80, 1'b1);
      take_result(1, 1'b0, 1'b0, 1, 1'b0);
      exp_q.push_back(16'h3F82);
      send_beat(16'h3F80, 16'h3B80, 16'h3F81, 1'b1);
      take_result(1, 1'b0, 1'b0, 1, 1'b0);
      exp_q.push_back(16'h0000);
      send_beat(16'hBF80, 16'h3F80, 16'h3F80, 1'b1);
      take_result(1, 1'b0, 1'b0, 1, 1'b0);

      // asynchronous reset mid-vector
      send_beat(16'h4000, 16'h4000, 16'h0000, 1'b0);
      send_beat(16'h4000, 16'h4000, 16'h0000, 1'b0);
      #1 rst = 1'b1;
      #1;
      check_eq("arst_state",  32'(dbg_state),       32'(ST_IDLE));
      check_eq("arst_count",  32'(u_if.out_count),  32'd0);
      check_eq("arst_result", 32'(u_if.out_result), 32'h0000);
      #1 rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(16'h40C0);
      send_beat(16'h4000, 16'h4040, 16'h0000, 1'b1);
      take_result(1, 1'b0, 1'b0, 1, 1'b0);

      // asynchronous reset during HOLD discards the result
      send_beat(16'h4000, 16'h4000, 16'h0000, 1'b1);
      #1 rst = 1'b1;
      #1;
      check_eq("hrst_valid",  32'(u_if.out_valid),  32'd0);
      check_eq("hrst_ready",  32'(u_if.in_ready),   32'd1);
      check_eq("hrst_result", 32'(u_if.out_result), 32'h0000);
      #1 rst = 1'b0;
      @(negedge clk);

      // five zero beats: narrow counter saturates at 3 and flags overflow
      for (int i = 0; i < 4; i++) send_beat(16'h0000, 16'h0000, 16'h0000, 1'b0);
      exp_q.push_back(16'h0000);
      send_beat(16'h0000, 16'h0000, 16'h0000, 1'b1);
      take_result(5, 1'b0, 1'b0, 3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
